// File: rtl/character_redraw_ctrl.sv
// -----------------------------------------------------------------------------
// character_redraw_ctrl
//
// Owns the player character's lane (0..3) and turns move requests into a
// stream of VGA pixel writes. An accepted move erases the box at the old lane
// in the background colour, then draws it at the new lane in the character
// colour, one pixel per clock, row-major.
//
// After reset the block draws lane 0 (INIT) before accepting any move.
//
// Optional feature (compile-time macro MOVE_QUEUE_EN):
//   When defined, a one-entry pending-move register captures a request that
//   arrives while a move is in progress. That request is started directly
//   from DONE. Its validity is judged against the lane committed at that
//   point, not against the lane at capture time.
//   When undefined, requests that arrive while busy are dropped.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   move_left_i     in   single-cycle request: move one lane left
//   move_right_i    in   single-cycle request: move one lane right
//   curr_pos_o      out  committed lane; updates when the draw pass starts
//   vga_x_o         out  pixel column to the VGA adapter
//   vga_y_o         out  pixel row to the VGA adapter
//   vga_colour_o    out  pixel colour
//   vga_plot_o      out  pixel write enable
//   busy_o          out  high while any pass (or DONE) is in progress
//   done_drawing_o  out  one-cycle pulse after a draw pass completes
// -----------------------------------------------------------------------------
module character_redraw_ctrl #(
    parameter int          CHAR_W      = 9,
    parameter int          CHAR_H      = 5,
    parameter int          CHAR_Y      = 102,
    parameter int          POS0_X      = 6,
    parameter int          POS1_X      = 24,
    parameter int          POS2_X      = 78,
    parameter int          POS3_X      = 132,
    parameter logic [2:0]  CHAR_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       move_left_i,
    input  logic       move_right_i,
    output logic [1:0] curr_pos_o,
    output logic [7:0] vga_x_o,
    output logic [6:0] vga_y_o,
    output logic [2:0] vga_colour_o,
    output logic       vga_plot_o,
    output logic       busy_o,
    output logic       done_drawing_o
);

    localparam int XW = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
    localparam int YW = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(CHAR_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(CHAR_H - 1);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_ERASE = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Left column of each lane.
    function automatic logic [7:0] lane_x(input logic [1:0] lane);
        logic [7:0] x;
        case (lane)
            2'd0:    x = 8'(POS0_X);
            2'd1:    x = 8'(POS1_X);
            2'd2:    x = 8'(POS2_X);
            default: x = 8'(POS3_X);
        endcase
        return x;
    endfunction

    // -------------------------------------------------------------------------
    // State
    //
    // The state and the scan counters describe what the output registers are
    // presenting right now. Outputs are therefore loaded from the *next*
    // state/counters, so the first pixel of a pass appears in the cycle right
    // after the edge that enters the pass.
    // -------------------------------------------------------------------------
    logic [2:0]    state_q,    state_d;
    logic [XW-1:0] xcnt_q,     xcnt_d;
    logic [YW-1:0] ycnt_q,     ycnt_d;
    logic [1:0]    old_lane_q, old_lane_d;
    logic [1:0]    new_lane_q, new_lane_d;

    logic [1:0]    curr_pos_q;
    logic [7:0]    vga_x_q;
    logic [6:0]    vga_y_q;
    logic [2:0]    vga_colour_q;
    logic          vga_plot_q;
    logic          busy_q;
    logic          done_q;

`ifdef MOVE_QUEUE_EN
    logic          pend_valid_q, pend_valid_d;
    logic          pend_right_q, pend_right_d;
`endif

    // -------------------------------------------------------------------------
    // Request decode. Both buttons together is treated as no request.
    // -------------------------------------------------------------------------
    logic       in_left;
    logic       in_right;
    logic       sel_valid;
    logic       sel_right;
    logic       start_ok;
    logic [1:0] start_target;

    assign in_left  = move_left_i  & ~move_right_i;
    assign in_right = move_right_i & ~move_left_i;

    always_comb begin
        sel_valid = in_left | in_right;
        sel_right = in_right;
`ifdef MOVE_QUEUE_EN
        // In DONE a request arriving this very cycle is the newest one and
        // wins; otherwise fall back to the stored move.
        if ((state_q == S_DONE) && !(in_left | in_right)) begin
            sel_valid = pend_valid_q;
            sel_right = pend_right_q;
        end
`endif
        // Validity is judged against the lane committed now.
        start_ok     = sel_valid &&
                       (sel_right ? (curr_pos_q != 2'd3) : (curr_pos_q != 2'd0));
        start_target = sel_right ? 2'(curr_pos_q + 2'd1) : 2'(curr_pos_q - 2'd1);
    end

    // -------------------------------------------------------------------------
    // Scan counter helpers
    // -------------------------------------------------------------------------
    logic          pixel_last;
    logic [XW-1:0] xcnt_adv;
    logic [YW-1:0] ycnt_adv;

    always_comb begin
        pixel_last = (xcnt_q == X_LAST) && (ycnt_q == Y_LAST);
        if (xcnt_q == X_LAST) begin
            xcnt_adv = '0;
            ycnt_adv = ycnt_q + YW'(1);
        end else begin
            xcnt_adv = xcnt_q + XW'(1);
            ycnt_adv = ycnt_q;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        xcnt_d     = xcnt_q;
        ycnt_d     = ycnt_q;
        old_lane_d = old_lane_q;
        new_lane_d = new_lane_q;
`ifdef MOVE_QUEUE_EN
        pend_valid_d = pend_valid_q;
        pend_right_d = pend_right_q;
`endif

        case (state_q)
            S_INIT: begin
                // Straight out of reset nothing is on the outputs yet, so the
                // first edge presents pixel (0,0) instead of advancing past it.
                if (vga_plot_q) begin
                    if (pixel_last) begin
                        state_d = S_DONE;
                        xcnt_d  = '0;
                        ycnt_d  = '0;
                    end else begin
                        xcnt_d  = xcnt_adv;
                        ycnt_d  = ycnt_adv;
                    end
                end
            end

            S_IDLE: begin
                if (start_ok) begin
                    state_d    = S_ERASE;
                    old_lane_d = curr_pos_q;
                    new_lane_d = start_target;
                    xcnt_d     = '0;
                    ycnt_d     = '0;
                end
            end

            S_ERASE, S_DRAW: begin
                if (pixel_last) begin
                    state_d = (state_q == S_ERASE) ? S_DRAW : S_DONE;
                    xcnt_d  = '0;
                    ycnt_d  = '0;
                end else begin
                    xcnt_d  = xcnt_adv;
                    ycnt_d  = ycnt_adv;
                end
`ifdef MOVE_QUEUE_EN
                if (in_left | in_right) begin
                    pend_valid_d = 1'b1;
                    pend_right_d = in_right;
                end
`endif
            end

            S_DONE: begin
                state_d = S_IDLE;
`ifdef MOVE_QUEUE_EN
                // A pending move skips IDLE and starts erasing next cycle.
                pend_valid_d = 1'b0;
                if (start_ok) begin
                    state_d    = S_ERASE;
                    old_lane_d = curr_pos_q;
                    new_lane_d = start_target;
                    xcnt_d     = '0;
                    ycnt_d     = '0;
                end
`endif
            end

            default: begin
                state_d = S_INIT;
                xcnt_d  = '0;
                ycnt_d  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state
    // -------------------------------------------------------------------------
    logic       scan_d;
    logic [1:0] scan_lane_d;
    logic [2:0] scan_colour_d;

    always_comb begin
        scan_d        = (state_d == S_INIT) || (state_d == S_ERASE) ||
                        (state_d == S_DRAW);
        scan_lane_d   = 2'd0;
        scan_colour_d = CHAR_COLOUR;
        if (state_d == S_ERASE) begin
            scan_lane_d   = old_lane_d;
            scan_colour_d = BG_COLOUR;
        end else if (state_d == S_DRAW) begin
            scan_lane_d   = new_lane_d;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            xcnt_q       <= '0;
            ycnt_q       <= '0;
            old_lane_q   <= 2'd0;
            new_lane_q   <= 2'd0;
            curr_pos_q   <= 2'd0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= BG_COLOUR;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            xcnt_q     <= xcnt_d;
            ycnt_q     <= ycnt_d;
            old_lane_q <= old_lane_d;
            new_lane_q <= new_lane_d;

            // The lane is committed as the draw pass begins.
            if ((state_d == S_DRAW) && (state_q != S_DRAW)) begin
                curr_pos_q <= new_lane_d;
            end

            // Position/colour hold their last value outside a pass.
            if (scan_d) begin
                vga_x_q      <= lane_x(scan_lane_d) + 8'(xcnt_d);
                vga_y_q      <= 7'(CHAR_Y) + 7'(ycnt_d);
                vga_colour_q <= scan_colour_d;
            end

            vga_plot_q <= scan_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end

`ifdef MOVE_QUEUE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_right_q <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_right_q <= pend_right_d;
        end
    end
`endif

    assign curr_pos_o     = curr_pos_q;
    assign vga_x_o        = vga_x_q;
    assign vga_y_o        = vga_y_q;
    assign vga_colour_o   = vga_colour_q;
    assign vga_plot_o     = vga_plot_q;
    assign busy_o         = busy_q;
    assign done_drawing_o = done_q;

endmodule

// File: tb/tb_character_redraw_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for character_redraw_ctrl.
// Expected pixels are pushed to a scoreboard queue when a move is issued and
// popped by a monitor on every plotted pixel. Directed steps run linearly in
// one initial block. Build with +define+MOVE_QUEUE_EN to cover the queue.
// -----------------------------------------------------------------------------
module tb_character_redraw_ctrl;

    localparam logic [2:0] CHAR_C = 3'b111;
    localparam logic [2:0] BG_C   = 3'b000;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       move_left;
    logic       move_right;
    logic [1:0] curr_pos;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done_drawing;

    pix_t exp_q[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   plot_cnt = 0;

    character_redraw_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .move_left_i    (move_left),
        .move_right_i   (move_right),
        .curr_pos_o     (curr_pos),
        .vga_x_o        (vga_x),
        .vga_y_o        (vga_y),
        .vga_colour_o   (vga_colour),
        .vga_plot_o     (vga_plot),
        .busy_o         (busy),
        .done_drawing_o (done_drawing)
    );

    always #5 clk = ~clk;

    function automatic int lane_left(input int lane);
        case (lane)
            0:       return 6;
            1:       return 24;
            2:       return 78;
            default: return 132;
        endcase
    endfunction

    task automatic push_box(input int lane, input logic [2:0] col);
        pix_t p;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 9; x++) begin
                p.x = 8'(lane_left(lane) + x);
                p.y = 7'(102 + y);
                p.c = col;
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every plotted pixel must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && vga_plot === 1'b1) begin
            pix_t got;
            pix_t exp;
            plot_cnt++;
            got = '{x: vga_x, y: vga_y, c: vga_colour};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $error("FAIL unexpected_plot: observed x=%0d y=%0d c=%0d expected no plot",
                       vga_x, vga_y, vga_colour);
            end else begin
                exp = exp_q.pop_front();
                assert (got === exp) else begin
                    n_err++;
                    $error("FAIL pixel: observed x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                           got.x, got.y, got.c, exp.x, exp.y, exp.c);
                end
            end
        end
    end

    task automatic reset_checks(input string pfx);
        chk({pfx, "_curr_pos"}, 32'(curr_pos), 0);
        chk({pfx, "_vga_x"},    32'(vga_x), 0);
        chk({pfx, "_vga_y"},    32'(vga_y), 0);
        chk({pfx, "_colour"},   32'(vga_colour), 32'(BG_C));
        chk({pfx, "_plot"},     32'(vga_plot), 0);
        chk({pfx, "_busy"},     32'(busy), 1);
        chk({pfx, "_done"},     32'(done_drawing), 0);
    endtask

    // Counts negedges until done_drawing is seen; bounded.
    task automatic wait_done(input string tag, output int cycles);
        bit seen;
        seen   = 0;
        cycles = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            cycles++;
            if (done_drawing === 1'b1) seen = 1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $error("FAIL %s_timeout: observed no done_drawing expected pulse within 300 cycles", tag);
        end
    endtask

    task automatic pulse(input logic l, input logic r);
        @(negedge clk);
        move_left  = l;
        move_right = r;
        @(negedge clk);
        move_left  = 1'b0;
        move_right = 1'b0;
    endtask

    // One full move. After pulse() returns we stand on the first-pixel cycle;
    // DoneDrawing is 90 negedges later (cycle 91 counting the first pixel as 1).
    task automatic run_move(input string tag, input logic l, input logic r,
                            input int from_lane, input int to_lane);
        int c;
        push_box(from_lane, BG_C);
        push_box(to_lane, CHAR_C);
        pulse(l, r);
        chk({tag, "_first_plot"}, 32'(vga_plot), 1);
        wait_done(tag, c);
        chk({tag, "_done_lat"}, 32'(c), 90);
        @(negedge clk);
        chk({tag, "_busy_low"}, 32'(busy), 0);
        chk({tag, "_curr_pos"}, 32'(curr_pos), 32'(to_lane));
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 0);
    endtask

    task automatic drop_check(input string tag, input logic l, input logic r, input int lane);
        int p0;
        p0 = plot_cnt;
        pulse(l, r);
        repeat (5) @(negedge clk);
        chk({tag, "_plots"},    32'(plot_cnt - p0), 0);
        chk({tag, "_busy"},     32'(busy), 0);
        chk({tag, "_curr_pos"}, 32'(curr_pos), 32'(lane));
    endtask

    initial begin
        int c;
        int p0;
        int lane;

        rst_n      = 1'b0;
        move_left  = 1'b0;
        move_right = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        reset_checks("rst");

        // Reset release: INIT draws lane 0; done on the 46th negedge.
        push_box(0, CHAR_C);
        rst_n = 1'b1;
        wait_done("init", c);
        chk("init_done_lat", 32'(c), 46);
        chk("init_plots",    32'(plot_cnt), 45);
        @(negedge clk);
        chk("init_busy_low", 32'(busy), 0);
        chk("init_curr_pos", 32'(curr_pos), 0);
        chk("init_done_off", 32'(done_drawing), 0);

        // Boundary: MoveLeft at lane 0 dropped.
        drop_check("left_at_0", 1'b1, 1'b0, 0);

        // 0 -> 1 with commit-timing checks.
        push_box(0, BG_C);
        push_box(1, CHAR_C);
        pulse(1'b0, 1'b1);
        chk("m01_first_plot", 32'(vga_plot), 1);
        chk("m01_first_colour", 32'(vga_colour), 32'(BG_C));
        repeat (44) @(negedge clk);
        chk("m01_pos_last_erase", 32'(curr_pos), 0);
        @(negedge clk);
        chk("m01_pos_draw_entry", 32'(curr_pos), 1);
        chk("m01_draw_colour", 32'(vga_colour), 32'(CHAR_C));
        wait_done("m01", c);
        chk("m01_done_lat", 32'(c), 45);
        @(negedge clk);
        chk("m01_busy_low", 32'(busy), 0);
        chk("m01_sb_empty", 32'(exp_q.size()), 0);

        // Boundary: both buttons together dropped.
        drop_check("both", 1'b1, 1'b1, 1);

        // 1 -> 2 -> 3, then MoveRight at 3 dropped.
        run_move("m12", 1'b0, 1'b1, 1, 2);
        run_move("m23", 1'b0, 1'b1, 2, 3);
        drop_check("right_at_3", 1'b0, 1'b1, 3);

        // Walk back to lane 0 with MoveLeft.
        run_move("m32", 1'b1, 1'b0, 3, 2);
        run_move("m21", 1'b1, 1'b0, 2, 1);
        run_move("m10", 1'b1, 1'b0, 1, 0);

        // MoveRight during ERASE of a 0 -> 1 move.
        p0 = plot_cnt;
        push_box(0, BG_C);
        push_box(1, CHAR_C);
        pulse(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        move_right = 1'b1;
        @(negedge clk);
        move_right = 1'b0;
        wait_done("busyreq", c);
`ifdef MOVE_QUEUE_EN
        push_box(1, BG_C);
        push_box(2, CHAR_C);
        @(negedge clk);
        chk("queued_start_plot", 32'(vga_plot), 1);
        chk("queued_start_busy", 32'(busy), 1);
        wait_done("queued", c);
        chk("queued_done_lat", 32'(c), 90);
        repeat (3) @(negedge clk);
        chk("queued_plots", 32'(plot_cnt - p0), 180);
        chk("queued_curr_pos", 32'(curr_pos), 2);
        lane = 2;
`else
        repeat (3) @(negedge clk);
        chk("busyreq_plots", 32'(plot_cnt - p0), 90);
        chk("busyreq_curr_pos", 32'(curr_pos), 1);
        lane = 1;
`endif
        chk("busyreq_busy_low", 32'(busy), 0);
        chk("busyreq_sb_empty", 32'(exp_q.size()), 0);

        // Reset at draw pixel 20 (negedge offset 65 from the first erase pixel).
        push_box(lane, BG_C);
        push_box(lane + 1, CHAR_C);
        pulse(1'b0, 1'b1);
        repeat (65) @(negedge clk);
        chk("midrst_pre_plot", 32'(vga_plot), 1);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        push_box(0, CHAR_C);
        rst_n = 1'b1;
        wait_done("reinit", c);
        chk("reinit_done_lat", 32'(c), 46);
        @(negedge clk);
        chk("reinit_curr_pos", 32'(curr_pos), 0);
        chk("reinit_sb_empty", 32'(exp_q.size()), 0);

        // Three back-to-back MoveRight requests.
        run_move("b01", 1'b0, 1'b1, 0, 1);
        run_move("b12", 1'b0, 1'b1, 1, 2);
        run_move("b23", 1'b0, 1'b1, 2, 3);
        repeat (5) @(negedge clk);
        chk("final_curr_pos", 32'(curr_pos), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
